// File: rtl/serial_rx_interface.sv
// Serial-to-parallel receiver: MSB-first 32-bit words into a 2-entry FIFO drained by req/grant.
// Optional even-parity bit per word when SERIAL_RX_PARITY_EN is defined.
module serial_rx_interface (
   input  logic        p_clk,
   input  logic        n_rst,
   input  logic        serial_data_in,
   input  logic        in_valid,
   input  logic        grant,
   output logic [31:0] parallel_data_out,
   output logic        req,
   output logic        frame_err,
   output logic        overflow,
   output logic        parity_err,
   output logic [1:0]  state_dbg
);

`ifdef SERIAL_RX_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
   localparam int ACC_W = 32;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
   localparam int ACC_W = 31;
`endif

   state_t             state, state_nxt;
   logic [5:0]         cnt, cnt_nxt;
   logic [ACC_W-1:0]   acc, acc_nxt;
   logic               push;
   logic [31:0]        push_word;
   logic               frame_err_nxt;
   logic               parity_err_nxt;

   logic [31:0]        mem [2];
   logic               wr_ptr, rd_ptr;
   logic [1:0]         count;
   logic               pop, full, do_push;

   // Without parity the last bit is appended directly, so the accumulator only holds 31 bits.
`ifdef SERIAL_RX_PARITY_EN
   assign push_word = acc;
`else
   assign push_word = {acc, serial_data_in};
`endif

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      acc_nxt        = acc;
      push           = 1'b0;
      frame_err_nxt  = 1'b0;
      parity_err_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               acc_nxt   = {acc[ACC_W-2:0], serial_data_in};
               cnt_nxt   = 6'd1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (!in_valid) begin
               frame_err_nxt = 1'b1;
               cnt_nxt       = 6'd0;
               state_nxt     = IDLE;
            end else begin
               acc_nxt = {acc[ACC_W-2:0], serial_data_in};
               if (cnt == 6'd31) begin
                  cnt_nxt = 6'd0;
`ifdef SERIAL_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  push      = 1'b1;
                  state_nxt = IDLE;
`endif
               end else begin
                  cnt_nxt = cnt + 6'd1;
               end
            end
         end
`ifdef SERIAL_RX_PARITY_EN
         PARITY: begin
            state_nxt = IDLE;
            if (!in_valid) begin
               frame_err_nxt = 1'b1;
            end else if ((^acc) ^ serial_data_in) begin
               parity_err_nxt = 1'b1;
            end else begin
               push = 1'b1;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge p_clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         cnt        <= 6'd0;
         acc        <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         acc        <= acc_nxt;
         frame_err  <= frame_err_nxt;
         parity_err <= parity_err_nxt;
      end
   end

   // A push while full is accepted only if the same edge also pops.
   assign req      = (count != 2'd0);
   assign full     = (count == 2'd2);
   assign pop      = req & grant;
   assign do_push  = push & (~full | pop);
   assign parallel_data_out = mem[rd_ptr];
   assign state_dbg = state;

   always_ff @(posedge p_clk or negedge n_rst) begin
      if (!n_rst) begin
         mem[0]   <= 32'd0;
         mem[1]   <= 32'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_word;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (push & full & ~pop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: doc/serial_rx_interface.md
SERIAL_RX_INTERFACE -- requirements
Module: serial_rx_interface

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low: p_clk input 1, rising-edge clock for all state.
REQ-002 SHALL have port n_rst, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port serial_data_in, input, 1 bit: serial data bit, sampled on the p_clk rising edge.
REQ-004 SHALL have port in_valid, input, 1 bit: frame qualifier; high for every bit of a word.
REQ-005 SHALL have port grant, input, 1 bit: consumer accepts the presented word.
REQ-006 SHALL have port parallel_data_out, output, 32 bits: head-of-buffer word.
REQ-007 SHALL have port req, output, 1 bit: parallel_data_out is valid (buffer not empty).
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a partial word is aborted.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag set when a word is dropped because the buffer is full.
REQ-010 SHALL have port parity_err, output, 1 bit: one-cycle pulse on parity mismatch (see Configuration).

Function
REQ-011 SHALL have an FSM with states IDLE, SHIFT and, only when parity is compiled in, PARITY.
REQ-012 IDLE: in_valid=1 SHALL sample bit 31 (MSB first), set bit counter=1, and go to SHIFT.
REQ-013 SHIFT: each cycle with in_valid=1 SHALL shift serial_data_in into the LSB and increment the counter (6-bit counter).
REQ-014 SHIFT: on the 32nd sampled bit the word SHALL complete, and the FSM SHALL go to IDLE (PARITY when compiled in).
REQ-015 Back-to-back words SHALL be supported: in_valid held high continuously makes the next bit after completion the MSB of the next word, with no gap cycle.
REQ-016 SHIFT/PARITY with in_valid=0 SHALL discard the partial word, pulse frame_err for 1 cycle, and go to IDLE.
REQ-017 The completed word SHALL be written to a 2-entry FIFO on the same edge that samples its last bit (or its parity bit); req SHALL be high in the following cycle.
REQ-018 req SHALL equal the FIFO-not-empty condition; parallel_data_out SHALL equal the FIFO head and be stable while req=1 and grant=0.
REQ-019 A pop SHALL occur on each edge where req=1 and grant=1; grant with req=0 SHALL be ignored.
REQ-020 FIFO pointers SHALL be 1-bit and wrap, with a 2-bit occupancy count of 0..2.
REQ-021 A push while full with no pop SHALL drop the new word and set overflow=1; the FIFO contents SHALL be unchanged.
REQ-022 A simultaneous push and pop while full SHALL accept both, with occupancy staying at 2 and overflow not set.
REQ-023 A simultaneous push and pop while the FIFO holds 1 word SHALL leave occupancy at 1, with the new word at the head the next cycle.
REQ-024 overflow SHALL clear only on reset.

Reset
REQ-025 On n_rst=0, regardless of p_clk, the block SHALL immediately force FSM=IDLE, counter=0, FIFO empty, req=0, parallel_data_out=0, frame_err=0, overflow=0, parity_err=0.
REQ-026 Reset mid-word SHALL discard the partial word without a frame_err pulse.
REQ-027 The first bit SHALL be sampled on the first rising edge after n_rst deasserts with in_valid=1.

Configuration
REQ-028 With the macro SERIAL_RX_PARITY_EN defined, each word SHALL be followed by one even-parity bit, sampled in state PARITY with in_valid=1 (33 cycles per word).
REQ-029 With SERIAL_RX_PARITY_EN, a mismatch SHALL drop the word (no push) and pulse parity_err for 1 cycle; a match SHALL push the word.
REQ-030 Without SERIAL_RX_PARITY_EN, the PARITY state and checker SHALL be absent, parity_err SHALL be tied to 0, and a word SHALL be 32 cycles.

Verification
REQ-031 Single word: reset, in_valid=1 for 32 cycles carrying 32'h1111_1111 MSB first, grant=1 -> req high 1 cycle after the last bit with parallel_data_out=32'h1111_1111, then req low.
REQ-032 Back-to-back with stalled consumer: 32'h1111_1111 followed by 32'hFFFF_FFFF, grant=0 -> req=1, head=32'h1111_1111; after one grant, head=32'hFFFF_FFFF.
REQ-033 Overflow: three words 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0001 with grant=0 -> overflow=1, FIFO holds the first two, and the third is lost.
REQ-034 Abort: in_valid drops after 10 bits -> frame_err pulse of 1 cycle, req stays 0, and the next full word of 32'hDEAD_BEEF is received correctly.
REQ-035 Reset mid-word after 20 bits -> all outputs 0 immediately, and a following word of 32'h1234_5678 is received intact.
REQ-036 With SERIAL_RX_PARITY_EN: 32'h0000_0003 with parity bit 1 -> parity_err pulse and req stays 0; with parity bit 0 -> word delivered.
